// File: rtl/aes128_cipher_core_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers for the cipher datapath
// and future decrypt/inverse-key blocks.
package aes128_cipher_core_pkg;

  localparam int AES_NR = 10;
  localparam int AES_NK = 4;

  // ST_MIX is only reachable when AES_TWO_CYCLE_ROUND_EN splits each round.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_MIX
  } fsm_t;

  // Byte (row, col) of a column-major state; byte 0 occupies bits [127:120].
  function automatic int byte_msb(input int row, input int col);
    return 127 - 8 * (4 * col + row);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] applied to one column {a0,a1,a2,a3}.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (bypassed on the last round), AddRoundKey.
// With AES_TWO_CYCLE_ROUND_EN the SubBytes result leaves via sub_out and re-enters registered on sub_in.
module aes_round_comb
  import aes128_cipher_core_pkg::*;
(
`ifdef AES_TWO_CYCLE_ROUND_EN
  output logic [127:0] sub_out,
  input  logic [127:0] sub_in,
`endif
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [127:0] sub_bytes;
  logic [127:0] shift_src;
  logic [127:0] shifted;
  logic [127:0] mixed;

  for (genvar k = 0; k < 16; k++) begin : g_sbox
    sbox u_sbox (
      .endereco (state_in[127-8*k -: 8]),
      .dado     (sub_bytes[127-8*k -: 8])
    );
  end

`ifdef AES_TWO_CYCLE_ROUND_EN
  assign sub_out   = sub_bytes;
  assign shift_src = sub_in;
`else
  assign shift_src = sub_bytes;
`endif

  // Row r rotates left by r byte positions across the four columns.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign shifted[byte_msb(r, c) -: 8] = shift_src[byte_msb(r, (c + r) % 4) -: 8];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
  end

  assign state_out = (last_round ? shifted : mixed) ^ round_key;

endmodule

// File: rtl/sbox.sv
// AES forward S-box: endereco is the input byte, dado the substituted byte.
module sbox (
  input  logic [7:0] endereco,
  output logic [7:0] dado
);

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dado = SBOX_TABLE[endereco];

endmodule

// File: rtl/aes128_cipher_core.sv
// Iterative AES-128 encryption core: FSM, round counter and state registers around aes_round_comb.
// Build macro AES_TWO_CYCLE_ROUND_EN registers SubBytes and spends two cycles per round.
module aes128_cipher_core
  import aes128_cipher_core_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [127:0]                    plaintext,
  input  logic [(NR+1)*32*AES_NK-1:0]     round_key_flat,
  input  logic                            key_valid,
  output logic [127:0]                    ciphertext,
  output logic                            busy,
  output logic                            done
);

  fsm_t         fsm;
  logic [3:0]   round;
  logic [127:0] state_q;
  logic [127:0] round_key;
  logic [127:0] round_out;
  logic [10:0]  rk_base;
  logic         last_round;
`ifdef AES_TWO_CYCLE_ROUND_EN
  logic [127:0] sub_q;
  logic [127:0] sub_bytes;
`endif

  assign rk_base    = {round, 7'd0};
  assign round_key  = round_key_flat[rk_base +: 128];
  assign last_round = (round == 4'(NR));

  aes_round_comb u_round (
`ifdef AES_TWO_CYCLE_ROUND_EN
    .sub_out    (sub_bytes),
    .sub_in     (sub_q),
`endif
    .state_in   (state_q),
    .round_key  (round_key),
    .last_round (last_round),
    .state_out  (round_out)
  );

  // NOTE: every register here updates with <= so all of them sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: wide datapath registers are reset too, so an aborted block never leaks into ciphertext.
      fsm        <= ST_IDLE;
      round      <= '0;
      state_q    <= '0;
      ciphertext <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef AES_TWO_CYCLE_ROUND_EN
      sub_q      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (start && key_valid) begin
            state_q <= plaintext ^ round_key_flat[127:0];
            round   <= 4'd1;
            busy    <= 1'b1;
            fsm     <= ST_ROUND;
          end
        end
`ifdef AES_TWO_CYCLE_ROUND_EN
        ST_ROUND: begin
          sub_q <= sub_bytes;
          fsm   <= ST_MIX;
        end
        ST_MIX: begin
`else
        ST_ROUND: begin
`endif
          state_q <= round_out;
          round   <= round + 4'd1;
          fsm     <= ST_ROUND;
          if (last_round) begin
            ciphertext <= round_out;
            done       <= 1'b1;
            busy       <= 1'b0;
            round      <= '0;
            fsm        <= ST_IDLE;
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_cipher_core.sv
// Self-checking bench for aes128_cipher_core: FIPS-197 vectors, random blocks vs. a byte-level AES model,
// start/key_valid guards, mid-operation reset and back-to-back operation.
module tb_aes128_cipher_core;

`ifdef AES_TWO_CYCLE_ROUND_EN
  localparam int RL = 2;
`else
  localparam int RL = 1;
`endif
  localparam int NR  = 10;
  localparam int LAT = NR * RL;

  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] S1_B   = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [127:0]  plaintext;
  logic [1407:0] round_key_flat;
  logic          key_valid;
  logic [127:0]  ciphertext;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  logic [7:0] sbox_tab [256];

  aes128_cipher_core dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .plaintext      (plaintext),
    .round_key_flat (round_key_flat),
    .key_valid      (key_valid),
    .ciphertext     (ciphertext),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s, aff_c;
    aff_c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ aff_c[i];
      sbox_tab[x] = s;
    end
  endtask

  function automatic logic [1407:0] expand_key(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] flat;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gf_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 11; i++) flat[i*128 +: 128] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
    return flat;
  endfunction

  function automatic logic [127:0] encrypt_ref(input logic [127:0] pt, input logic [1407:0] rkf);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] rk, res;
    rk = rkf[127:0];
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk[127-8*k -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      rk = rkf[rnd*128 +: 128];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r+4*c] = sbox_tab[s[r + 4*((c+r)%4)]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rnd < 10)
            s[4*c+r] = gf_mul(8'h02, t[4*c+r]) ^ gf_mul(8'h03, t[4*c+(r+1)%4]) ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
          else
            s[4*c+r] = t[4*c+r];
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk[127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start, then measures edges to done and busy cycles; returns in the done cycle.
  task automatic run_block(input logic [127:0] pt, output int done_edge, output int busy_cycles,
                           output logic [127:0] state_r1);
    start     = 1'b1;
    plaintext = pt;
    tick();
    start       = 1'b0;
    plaintext   = rand128();
    busy_cycles = int'(busy);
    done_edge   = -1;
    state_r1    = '0;
    for (int i = 1; i <= LAT + 8; i++) begin
      tick();
      if (i == RL) state_r1 = dut.state_q;
      busy_cycles += int'(busy);
      if (done) begin
        done_edge = i;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; key_valid = 1'b1; plaintext = '0;
    round_key_flat = expand_key(KEY_B);
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (ciphertext !== '0) begin errors++; $display("FAIL reset_ct: got %h expected 0", ciphertext); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fips_b();
    int de, bc;
    logic [127:0] s1;
    round_key_flat = expand_key(KEY_B);
    run_block(PT_B, de, bc, s1);
    checks++; if (de != LAT) begin errors++; $display("FAIL b_latency: got %0d expected %0d", de, LAT); end
    checks++; if (ciphertext !== CT_B) begin errors++; $display("FAIL b_ct: got %h expected %h", ciphertext, CT_B); end
    checks++; if (bc != LAT) begin errors++; $display("FAIL b_busy_cycles: got %0d expected %0d", bc, LAT); end
    checks++; if (s1 !== S1_B) begin errors++; $display("FAIL b_round1_state: got %h expected %h", s1, S1_B); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b_done_width: got %b expected 0", done); end
  endtask

  task automatic test_fips_c1();
    int de, bc;
    logic [127:0] s1;
    round_key_flat = expand_key(KEY_C1);
    run_block(PT_C1, de, bc, s1);
    checks++; if (de != LAT) begin errors++; $display("FAIL c1_latency: got %0d expected %0d", de, LAT); end
    checks++; if (ciphertext !== CT_C1) begin errors++; $display("FAIL c1_ct: got %h expected %h", ciphertext, CT_C1); end
    checks++; if (bc != LAT) begin errors++; $display("FAIL c1_busy_cycles: got %0d expected %0d", bc, LAT); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL c1_done_width: got %b expected 0", done); end
  endtask

  task automatic test_random();
    int de, bc;
    logic [127:0] s1, key, pt, exp_ct;
    for (int n = 0; n < 20; n++) begin
      key = rand128();
      pt  = rand128();
      round_key_flat = expand_key(key);
      exp_ct = encrypt_ref(pt, round_key_flat);
      run_block(pt, de, bc, s1);
      checks++; if (de != LAT) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, de, LAT); end
      checks++; if (ciphertext !== exp_ct) begin errors++; $display("FAIL rand_ct[%0d]: got %h expected %h", n, ciphertext, exp_ct); end
    end
    tick();
  endtask

  task automatic test_start_held();
    int done_edges[$];
    int exp_edge;
    round_key_flat = expand_key(KEY_C1);
    plaintext = PT_C1;
    start = 1'b1;
    for (int e = 0; e < 4 * (LAT + 1) + 4; e++) begin
      tick();
      if (e == 3 * (LAT + 1) - 1) start = 1'b0;
      if (done) done_edges.push_back(e);
    end
    checks++; if (done_edges.size() != 3) begin errors++; $display("FAIL held_done_count: got %0d expected 3", done_edges.size()); end
    for (int k = 0; k < 3 && k < done_edges.size(); k++) begin
      exp_edge = LAT + k * (LAT + 1);
      checks++; if (done_edges[k] != exp_edge) begin errors++; $display("FAIL held_done_edge[%0d]: got %0d expected %0d", k, done_edges[k], exp_edge); end
    end
    checks++; if (ciphertext !== CT_C1) begin errors++; $display("FAIL held_ct: got %h expected %h", ciphertext, CT_C1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_key_invalid();
    int de, bc;
    logic [127:0] s1;
    logic saw_busy, saw_done;
    round_key_flat = expand_key(KEY_B);
    run_block(PT_B, de, bc, s1);
    tick();
    key_valid = 1'b0; start = 1'b1; plaintext = rand128();
    saw_busy = 1'b0; saw_done = 1'b0;
    for (int i = 0; i < 2 * LAT + 4; i++) begin
      tick();
      saw_busy |= busy;
      saw_done |= done;
    end
    start = 1'b0; key_valid = 1'b1;
    checks++; if (saw_busy !== 1'b0) begin errors++; $display("FAIL nokey_busy: got %b expected 0", saw_busy); end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL nokey_done: got %b expected 0", saw_done); end
    checks++; if (ciphertext !== CT_B) begin errors++; $display("FAIL nokey_ct: got %h expected %h", ciphertext, CT_B); end
  endtask

  task automatic test_reset_mid();
    int de, bc;
    logic [127:0] s1;
    round_key_flat = expand_key(KEY_B);
    start = 1'b1; plaintext = PT_B;
    tick();
    start = 1'b0;
    repeat (5 * RL) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
    checks++; if (ciphertext !== '0) begin errors++; $display("FAIL midrst_ct: got %h expected 0", ciphertext); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    round_key_flat = expand_key(KEY_C1);
    run_block(PT_C1, de, bc, s1);
    checks++; if (de != LAT) begin errors++; $display("FAIL midrst_latency: got %0d expected %0d", de, LAT); end
    checks++; if (ciphertext !== CT_C1) begin errors++; $display("FAIL midrst_ct_after: got %h expected %h", ciphertext, CT_C1); end
    tick();
  endtask

  task automatic test_back_to_back();
    int de, bc, second;
    logic [127:0] s1;
    logic held_ok;
    round_key_flat = expand_key(KEY_B);
    run_block(PT_B, de, bc, s1);
    checks++; if (ciphertext !== CT_B) begin errors++; $display("FAIL b2b_first_ct: got %h expected %h", ciphertext, CT_B); end
    // Still in the done cycle: next request goes in immediately.
    round_key_flat = expand_key(KEY_C1);
    plaintext = PT_C1;
    start = 1'b1;
    held_ok = 1'b1;
    second = -1;
    for (int i = 1; i <= LAT + 8; i++) begin
      tick();
      if (i == 1) start = 1'b0;
      if (done) begin
        second = i;
        break;
      end
      if (ciphertext !== CT_B) held_ok = 1'b0;
    end
    checks++; if (second != LAT + 1) begin errors++; $display("FAIL b2b_second_done: got %0d expected %0d", second, LAT + 1); end
    checks++; if (held_ok !== 1'b1) begin errors++; $display("FAIL b2b_first_ct_held: got %b expected 1", held_ok); end
    checks++; if (ciphertext !== CT_C1) begin errors++; $display("FAIL b2b_second_ct: got %h expected %h", ciphertext, CT_C1); end
    tick();
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_random();
    test_start_held();
    test_key_invalid();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
